// File: rtl/niu32_mmio_ctrl_if.sv
// CPU-side MMIO bus bundle for niu32_mmio_ctrl.
// master = CPU load/store unit, slave = I/O controller.
interface niu32_mmio_ctrl_if #(
  parameter int WORD_SIZE = 32
);
  logic [WORD_SIZE-1:0] addr;
  logic [WORD_SIZE-1:0] wdata;
  logic                 wr_en;
  logic                 rd_en;
  logic                 io_hit;
  logic [WORD_SIZE-1:0] rdata;
  logic                 rd_valid;

  modport master (
    output addr, wdata, wr_en, rd_en,
    input  io_hit, rdata, rd_valid
  );

  modport slave (
    input  addr, wdata, wr_en, rd_en,
    output io_hit, rdata, rd_valid
  );
endinterface

// File: rtl/niu32_mmio_ctrl.sv
// niu32 MMIO: HEX/LED outputs, debounced keys, switches.
// Define NIU32_MMIO_KEY_EDGE_EN to build the KEYEDGE press latch.
module niu32_mmio_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WORD_SIZE       = 32
) (
  input  logic               clk,
  input  logic               reset,
  niu32_mmio_ctrl_if.slave   bus,
  input  logic [3:0]         key_n,
  input  logic [9:0]         sw,
  output logic [15:0]        hex_out,
  output logic [9:0]         ledr_out,
  output logic [7:0]         ledg_out
);
  localparam logic [WORD_SIZE-1:0] A_HEX  = WORD_SIZE'(32'hFFFF_0000);
  localparam logic [WORD_SIZE-1:0] A_LEDR = WORD_SIZE'(32'hFFFF_0020);
  localparam logic [WORD_SIZE-1:0] A_LEDG = WORD_SIZE'(32'hFFFF_0040);
  localparam logic [WORD_SIZE-1:0] A_KEY  = WORD_SIZE'(32'hFFFF_0100);
  localparam logic [WORD_SIZE-1:0] A_KEDG = WORD_SIZE'(32'hFFFF_0104);
  localparam logic [WORD_SIZE-1:0] A_SW   = WORD_SIZE'(32'hFFFF_0120);
  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  logic hit_hex, hit_ledr, hit_ledg;
  logic hit_key, hit_kedg, hit_sw;

  always_comb begin
    hit_hex  = (bus.addr == A_HEX);
    hit_ledr = (bus.addr == A_LEDR);
    hit_ledg = (bus.addr == A_LEDG);
    hit_key  = (bus.addr == A_KEY);
    hit_kedg = (bus.addr == A_KEDG);
    hit_sw   = (bus.addr == A_SW);
  end

  assign bus.io_hit = hit_hex | hit_ledr | hit_ledg |
                      hit_key | hit_kedg | hit_sw;

  logic [3:0]  key_s1, key_s2;
  logic [9:0]  sw_s1, sw_s2;
  logic [3:0]  kstate, kstate_d;
  logic [3:0]  level, rise;
  logic [15:0] cnt   [4];
  logic [15:0] cnt_d [4];

  assign level = ~key_s2;

  // Saturating compare keeps the counter at or below CNT_MAX.
  always_comb begin
    kstate_d = kstate;
    rise     = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (level[i] != kstate[i]) begin
        if (cnt[i] >= CNT_MAX) begin
          kstate_d[i] = level[i];
          rise[i]     = level[i];
        end else begin
          cnt_d[i] = cnt[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1 <= 4'hF;
      key_s2 <= 4'hF;
      sw_s1  <= '0;
      sw_s2  <= '0;
      kstate <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      kstate <= kstate_d;
      for (int i = 0; i < 4; i++) cnt[i] <= cnt_d[i];
    end
  end

  logic [3:0] edge_rd;

`ifdef NIU32_MMIO_KEY_EDGE_EN
  logic [3:0] key_edge;
  logic [3:0] edge_clr;

  assign edge_clr = (bus.wr_en && hit_kedg) ? bus.wdata[3:0] : 4'h0;

  // A press in the clearing cycle still wins.
  always_ff @(posedge clk) begin
    if (reset) key_edge <= '0;
    else       key_edge <= (key_edge & ~edge_clr) | rise;
  end

  assign edge_rd = key_edge;
`else
  assign edge_rd = '0;
`endif

  logic unused;
  assign unused = ^{bus.wdata[WORD_SIZE-1:16], rise};

  logic [WORD_SIZE-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      hit_hex:  rd_mux = WORD_SIZE'(hex_out);
      hit_ledr: rd_mux = WORD_SIZE'(ledr_out);
      hit_ledg: rd_mux = WORD_SIZE'(ledg_out);
      hit_key:  rd_mux = WORD_SIZE'(kstate);
      hit_kedg: rd_mux = WORD_SIZE'(edge_rd);
      hit_sw:   rd_mux = WORD_SIZE'(sw_s2);
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hex_out      <= '0;
      ledr_out     <= '0;
      ledg_out     <= '0;
      bus.rdata    <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      if (bus.wr_en && hit_hex)  hex_out  <= bus.wdata[15:0];
      if (bus.wr_en && hit_ledr) ledr_out <= bus.wdata[9:0];
      if (bus.wr_en && hit_ledg) ledg_out <= bus.wdata[7:0];
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) bus.rdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_niu32_mmio_ctrl.sv
// Directed bench for niu32_mmio_ctrl.
// Edge-latch checks follow NIU32_MMIO_KEY_EDGE_EN.
module tb_niu32_mmio_ctrl;
  localparam int DB = 16;
  localparam logic [31:0] A_HEX  = 32'hFFFF_0000;
  localparam logic [31:0] A_LEDR = 32'hFFFF_0020;
  localparam logic [31:0] A_LEDG = 32'hFFFF_0040;
  localparam logic [31:0] A_KEY  = 32'hFFFF_0100;
  localparam logic [31:0] A_KEDG = 32'hFFFF_0104;
  localparam logic [31:0] A_SW   = 32'hFFFF_0120;
  localparam logic [31:0] A_BAD  = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_n;
  logic [9:0]  sw;
  logic [15:0] hex_out;
  logic [9:0]  ledr_out;
  logic [7:0]  ledg_out;
  logic        hit;
  int total = 0;
  int bad   = 0;

  niu32_mmio_ctrl_if #(.WORD_SIZE(32)) bus ();

  niu32_mmio_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .WORD_SIZE(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .key_n(key_n),
    .sw(sw),
    .hex_out(hex_out),
    .ledr_out(ledr_out),
    .ledg_out(ledg_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.wr_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    bus.addr  = a;
    bus.rd_en = 1'b1;
    #1 hit = bus.io_hit;
    tick();
    bus.rd_en = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    key_n     = 4'hF;
    sw        = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    tick(2);
    check("rst hex", 32'(hex_out), 32'h0);
    check("rst ledr", 32'(ledr_out), 32'h0);
    check("rst ledg", 32'(ledg_out), 32'h0);
    check("rst rv", 32'(bus.rd_valid), 32'h0);
    check("rst rdata", bus.rdata, 32'h0);
    reset = 1'b0;

    wr(A_HEX, 32'h0000_BEEF);
    check("hex wr", 32'(hex_out), 32'hBEEF);
    rd(A_HEX);
    check("hex hit", 32'(hit), 32'h1);
    check("hex rv", 32'(bus.rd_valid), 32'h1);
    check("hex rd", bus.rdata, 32'h0000_BEEF);
    tick();
    check("rv drop", 32'(bus.rd_valid), 32'h0);

    wr(A_LEDG, 32'hFFFF_FFA5);
    check("ledg wr", 32'(ledg_out), 32'hA5);
    rd(A_LEDG);
    check("ledg rd", bus.rdata, 32'h0000_00A5);

    key_n = 4'b1101;
    tick(DB + 1);
    rd(A_KEY);
    check("key1 early", bus.rdata, 32'h0);
    rd(A_KEY);
    check("key1 acc", bus.rdata, 32'h2);
    key_n = 4'hF;
    tick(DB + 4);
    rd(A_KEY);
    check("key1 rel", bus.rdata, 32'h0);

    key_n = 4'b1011;
    tick(2 + DB + 2);
    key_n = 4'hF;
    rd(A_KEY);
    check("key2 press", bus.rdata, 32'h4);
    tick(DB + 4);
    rd(A_KEY);
    check("key2 rel", bus.rdata, 32'h0);
    key_n = 4'b1011;
    tick(5);
    key_n = 4'hF;
    tick(DB + 4);
    rd(A_KEY);
    check("key2 glitch", bus.rdata, 32'h0);

    bus.addr  = A_LEDR;
    bus.wdata = 32'h0000_03FF;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check("rw rv", 32'(bus.rd_valid), 32'h1);
    check("rw old", bus.rdata, 32'h0);
    check("ledr wr", 32'(ledr_out), 32'h3FF);

    wr(A_SW, 32'hFFFF_FFFF);
    wr(A_KEY, 32'hFFFF_FFFF);
    wr(A_BAD, 32'hFFFF_FFFF);
    check("ro hex", 32'(hex_out), 32'hBEEF);
    check("ro ledr", 32'(ledr_out), 32'h3FF);
    check("ro ledg", 32'(ledg_out), 32'hA5);

    sw = 10'h2A5;
    tick(2);
    rd(A_SW);
    check("sw rd", bus.rdata, 32'h0000_02A5);
    sw = 10'h15A;
    tick(1);
    rd(A_SW);
    check("sw lag", bus.rdata, 32'h0000_02A5);
    rd(A_SW);
    check("sw new", bus.rdata, 32'h0000_015A);

`ifdef NIU32_MMIO_KEY_EDGE_EN
    rd(A_KEDG);
    check("edge hist", bus.rdata, 32'h6);
    wr(A_KEDG, 32'hF);
    rd(A_KEDG);
    check("edge clr all", bus.rdata, 32'h0);
    key_n = 4'b1110;
    tick(2 + DB + 2);
    rd(A_KEDG);
    check("edge set", bus.rdata, 32'h1);
    wr(A_KEDG, 32'h1);
    rd(A_KEDG);
    check("edge clr", bus.rdata, 32'h0);
    key_n = 4'hF;
    tick(DB + 4);
    key_n = 4'b1110;
    tick(DB + 1);
    wr(A_KEDG, 32'h1);
    rd(A_KEDG);
    check("edge set wins", bus.rdata, 32'h1);
    key_n = 4'hF;
    tick(DB + 4);
`else
    rd(A_KEDG);
    check("kedg hit", 32'(hit), 32'h1);
    check("kedg rd", bus.rdata, 32'h0);
    wr(A_KEDG, 32'hF);
    rd(A_KEDG);
    check("kedg wr", bus.rdata, 32'h0);
`endif

    rd(A_HEX);
    rd(A_BAD);
    check("bad hit", 32'(hit), 32'h0);
    check("bad rv", 32'(bus.rd_valid), 32'h1);
    check("bad rd", bus.rdata, 32'h0);

    bus.addr  = A_HEX;
    bus.rd_en = 1'b1;
    tick();
    check("pend rv", 32'(bus.rd_valid), 32'h1);
    reset     = 1'b1;
    bus.wdata = 32'h0000_1234;
    bus.wr_en = 1'b1;
    tick();
    check("rst rv drop", 32'(bus.rd_valid), 32'h0);
    check("rst rdata2", bus.rdata, 32'h0);
    check("rst hex2", 32'(hex_out), 32'h0);
    check("rst ledr2", 32'(ledr_out), 32'h0);
    check("rst ledg2", 32'(ledg_out), 32'h0);
    reset     = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    tick();
    check("post rst rv", 32'(bus.rd_valid), 32'h0);
    check("post rst hex", 32'(hex_out), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
